// File: rtl/aes_pkg.sv
// Shared types, round-constant table and GF(2^8) helpers for the AES-128 key schedule.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    // Rcon[i] for i = 1..10, stored at index i-1
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] rcon_for(input logic [3:0] idx);
        logic [7:0] value;
        value = 8'h00;
        for (int k = 0; k < 10; k++) begin
            if (idx == 4'(k + 1)) begin
                value = RCON[k];
            end
        end
        return value;
    endfunction

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] product;
        logic [7:0] shifted;
        product = 8'h00;
        shifted = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                product = product ^ shifted;
            end
            shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? 8'h1b : 8'h00);
        end
        return product;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] result
);

    logic [7:0] power;
    logic [7:0] inverse;

    // x^254 = x^2 * x^4 * ... * x^128, which is the inverse for x != 0 and 0 for x == 0
    always_comb begin
        power   = gf_mul(value, value);
        inverse = power;
        for (int i = 0; i < 6; i++) begin
            power   = gf_mul(power, power);
            inverse = gf_mul(inverse, power);
        end
        result = inverse
               ^ {inverse[6:0], inverse[7]}
               ^ {inverse[5:0], inverse[7:6]}
               ^ {inverse[4:0], inverse[7:5]}
               ^ {inverse[3:0], inverse[7:4]}
               ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion streaming rk0..rk10 over a valid/ready handshake.
// Optional AES_KEY_ABORT_EN adds an abort input that drops an expansion in progress.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         busy
`ifdef AES_KEY_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    state_t state;
    word_t  rot_word;
    word_t  sub_word;
    word_t  temp_word;
    word_t  w0_next;
    word_t  w1_next;
    word_t  w2_next;
    word_t  w3_next;

    assign rot_word = {rk[23:0], rk[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub_word
        aes_sbox u_sbox (
            .value  (rot_word[8*b +: 8]),
            .result (sub_word[8*b +: 8])
        );
    end

    // Rcon index is the round being produced, one ahead of the key currently shown
    assign temp_word = sub_word ^ {rcon_for(rk_idx + 4'd1), 24'h000000};
    assign w0_next   = rk[127:96] ^ temp_word;
    assign w1_next   = rk[95:64]  ^ w0_next;
    assign w2_next   = rk[63:32]  ^ w1_next;
    assign w3_next   = rk[31:0]   ^ w2_next;

    assign busy    = (state != IDLE);
    assign rk_last = rk_valid && (rk_idx == LAST_IDX);

    // key_ready is registered so it stays low through reset and rises on the first edge after it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            key_ready <= 1'b0;
            rk_valid  <= 1'b0;
            rk        <= '0;
            rk_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    key_ready <= 1'b1;
                    if (key_valid && key_ready) begin
                        rk        <= key;
                        rk_idx    <= 4'd0;
                        rk_valid  <= 1'b1;
                        key_ready <= 1'b0;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
`ifdef AES_KEY_ABORT_EN
                    if (abort) begin
                        rk_valid  <= 1'b0;
                        key_ready <= 1'b1;
                        state     <= IDLE;
                    end else
`endif
                    if (rk_valid && rk_ready) begin
                        if (rk_idx == LAST_IDX) begin
                            rk_valid  <= 1'b0;
                            key_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            rk     <= {w0_next, w1_next, w2_next, w3_next};
                            rk_idx <= rk_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
